// File: rtl/wb_writer.sv
// Writeback stage: WB register plus one-entry skid buffer feeding the register-file write port,
// with forwarding selects and decode stall. Optional WB_COMMIT_CNT_EN adds a 16-bit commit counter.
module wb_writer #(
  parameter int unsigned REG_DATA_WIDTH    = 16,
  parameter int unsigned REG_NUM_WIDTH     = 4,
  parameter int unsigned REG_FORWARD_WIDTH = 2,
  parameter int unsigned NUM_REG           = 16,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = 2'b01,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = 2'b10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_valid,
  output logic                         ex_ready,
  input  logic                         ex_wr,
  input  logic [REG_NUM_WIDTH-1:0]     ex_wrn,
  input  logic [REG_DATA_WIDTH-1:0]    ex_wrd,
  input  logic                         ex_wr0,
  input  logic [REG_DATA_WIDTH-1:0]    ex_r0d,
  input  logic                         wb_hold,
  input  logic [REG_NUM_WIDTH-1:0]     rn_1,
  input  logic [REG_NUM_WIDTH-1:0]     rn_2,
  output logic [REG_NUM_WIDTH-1:0]     wrn,
  output logic [REG_DATA_WIDTH-1:0]    wrd,
  output logic                         wr,
  output logic                         wr0,
  output logic [REG_DATA_WIDTH-1:0]    r0d,
  output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
  output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
  output logic                         fwd_stall,
  output logic                         wr_exc
`ifdef WB_COMMIT_CNT_EN
  ,
  output logic [15:0]                  commit_cnt
`endif
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t state_q, state_d;
  logic   rdy_q;
  logic   wr_exc_q;

  logic                      wb_wr_q, wb_wr0_q;
  logic [REG_NUM_WIDTH-1:0]  wb_wrn_q;
  logic [REG_DATA_WIDTH-1:0] wb_wrd_q, wb_r0d_q;
  logic                      sk_wr_q, sk_wr0_q;
  logic [REG_NUM_WIDTH-1:0]  sk_wrn_q;
  logic [REG_DATA_WIDTH-1:0] sk_wrd_q, sk_r0d_q;

  logic wb_vld, sk_vld, xfer, commit, wrn_legal;
  logic ld_wb_ex, ld_wb_sk, ld_sk;

  assign wb_vld    = (state_q != ST_EMPTY);
  assign sk_vld    = (state_q == ST_SKID);
  assign ex_ready  = rdy_q & (state_q != ST_SKID);
  assign xfer      = ex_valid & ex_ready;
  assign commit    = wb_vld & ~wb_hold;
  assign wrn_legal = (32'(ex_wrn) < NUM_REG);

  // Next-state and load-enable decode
  always_comb begin
    state_d  = state_q;
    ld_wb_ex = 1'b0;
    ld_wb_sk = 1'b0;
    ld_sk    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          ld_wb_ex = 1'b1;
          state_d  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (commit && xfer) begin
          ld_wb_ex = 1'b1;
        end else if (commit) begin
          state_d = ST_EMPTY;
        end else if (xfer) begin
          ld_sk   = 1'b1;
          state_d = ST_SKID;
        end
      end
      ST_SKID: begin
        if (commit) begin
          ld_wb_sk = 1'b1;
          state_d  = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, ready flag and exception pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      rdy_q    <= 1'b0;
      wr_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      wr_exc_q <= xfer & ex_wr & ~wrn_legal;
    end
  end

  // WB and skid entries; an illegal destination keeps its R0 half but loses wr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wr_q  <= 1'b0;
      wb_wr0_q <= 1'b0;
      wb_wrn_q <= '0;
      wb_wrd_q <= '0;
      wb_r0d_q <= '0;
      sk_wr_q  <= 1'b0;
      sk_wr0_q <= 1'b0;
      sk_wrn_q <= '0;
      sk_wrd_q <= '0;
      sk_r0d_q <= '0;
    end else begin
      if (ld_wb_ex) begin
        wb_wr_q  <= ex_wr & wrn_legal;
        wb_wr0_q <= ex_wr0;
        wb_wrn_q <= ex_wrn;
        wb_wrd_q <= ex_wrd;
        wb_r0d_q <= ex_r0d;
      end else if (ld_wb_sk) begin
        wb_wr_q  <= sk_wr_q;
        wb_wr0_q <= sk_wr0_q;
        wb_wrn_q <= sk_wrn_q;
        wb_wrd_q <= sk_wrd_q;
        wb_r0d_q <= sk_r0d_q;
      end
      if (ld_sk) begin
        sk_wr_q  <= ex_wr & wrn_legal;
        sk_wr0_q <= ex_wr0;
        sk_wrn_q <= ex_wrn;
        sk_wrd_q <= ex_wrd;
        sk_r0d_q <= ex_r0d;
      end
    end
  end

  assign wr     = wb_vld & wb_wr_q & ~wb_hold;
  assign wr0    = wb_vld & wb_wr0_q & ~wb_hold;
  assign wrn    = wb_vld ? wb_wrn_q : '0;
  assign wrd    = wb_vld ? wb_wrd_q : '0;
  assign r0d    = wb_vld ? wb_r0d_q : '0;
  assign wr_exc = wr_exc_q;

  // R0 wins over WB since the register file applies wr0 after wr
  function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(
    input logic [REG_NUM_WIDTH-1:0] rn, input logic w, input logic w0,
    input logic [REG_NUM_WIDTH-1:0] n);
    if (w0 && (rn == '0))   return REG_FORWARD_R0;
    else if (w && (n == rn)) return REG_FORWARD_WB;
    else                     return REG_FORWARD_REG_FILE;
  endfunction

  function automatic logic pending_hit(
    input logic [REG_NUM_WIDTH-1:0] rn, input logic v, input logic w, input logic w0,
    input logic [REG_NUM_WIDTH-1:0] n);
    return v & ((w & (n == rn)) | (w0 & (rn == '0)));
  endfunction

  assign reg_forward_1 = fwd_sel(rn_1, wr, wr0, wrn);
  assign reg_forward_2 = fwd_sel(rn_2, wr, wr0, wrn);

  assign fwd_stall =
      pending_hit(rn_1, wb_vld & wb_hold, wb_wr_q, wb_wr0_q, wb_wrn_q) |
      pending_hit(rn_2, wb_vld & wb_hold, wb_wr_q, wb_wr0_q, wb_wrn_q) |
      pending_hit(rn_1, sk_vld, sk_wr_q, sk_wr0_q, sk_wrn_q) |
      pending_hit(rn_2, sk_vld, sk_wr_q, sk_wr0_q, sk_wrn_q);

`ifdef WB_COMMIT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Counts commits that actually write; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (commit && (wr || wr0)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign commit_cnt = cnt_q;
`endif

endmodule
